// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, stop bit lasting SB_TICK s_ticks.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_start,
  input  logic               s_tick,
  input  logic [NB_DATA-1:0] tx_data,
  output logic               tx_done_tick,
  output logic               tx_busy,
  output logic               tx
);

  // Tick counter must cover both the 16-tick bit period and the SB_TICK stop period.
  localparam int unsigned TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(15);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [NB_DATA-1:0]   sreg_q, sreg_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      sreg_q   <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      sreg_q   <= sreg_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          sreg_d   = tx_data;
          tick_d   = '0;
          state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            sreg_d = sreg_q >> 1;
            bit_d  = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so tx changes on the same edge as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && s_tick && (tick_q == STOP_LAST);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = sreg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected line level is derived from elapsed s_tick count and the frame bit list.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       tx_start0, tx_start1;
  logic       s_tick;
  logic [7:0] tx_data;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx #(.NB_DATA(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start0), .s_tick(s_tick),
    .tx_data(tx_data), .tx_done_tick(done0), .tx_busy(busy0), .tx(tx0)
  );

  uart_tx #(.NB_DATA(8), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .tx_start(tx_start1), .s_tick(s_tick),
    .tx_data(tx_data), .tx_done_tick(done1), .tx_busy(busy1), .tx(tx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq lists the data bits in transmission order, first bit in seq[7].
  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    logic       par;
    int         period;
    bit         sel;
    int         spur_k;
    bit         start_at_end;
    int         abort_k;
    bit         tail;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit start, input bit tick, input logic [7:0] d, input bit sel);
    tx_start0 = sel ? 1'b0 : start;
    tx_start1 = sel ? start : 1'b0;
    s_tick    = tick;
    tx_data   = d;
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    logic bits [0:10];
    int   nb, sb, total, t, k, bi;
    bit   is_tick, st;
    logic etx;
    sb = v.sel ? 32 : 16;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = v.seq[7-i];
    nb = 9;
`ifdef UART_TX_PARITY_EN
    bits[9] = v.par;
    nb = 10;
`endif
    total = nb * 16 + sb;
    t = 0;
    k = 0;
    drive(1'b1, 1'b0, v.data, v.sel);
    @(posedge clk); #1;
    chk($sformatf("v%0d accept tx", idx), v.sel ? tx1 : tx0, 1'b0);
    chk($sformatf("v%0d accept busy", idx), v.sel ? busy1 : busy0, 1'b1);
    while (t < total) begin
      k++;
      if (k == v.abort_k) begin
        drive(1'b0, 1'b1, 8'h00, v.sel);
        reset = 1'b0;
        #1;
        chk($sformatf("v%0d abort tx", idx), v.sel ? tx1 : tx0, 1'b1);
        chk($sformatf("v%0d abort busy", idx), v.sel ? busy1 : busy0, 1'b0);
        chk($sformatf("v%0d abort done", idx), v.sel ? done1 : done0, 1'b0);
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          chk($sformatf("v%0d abort hold done", idx), v.sel ? done1 : done0, 1'b0);
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, v.sel);
        @(posedge clk); #1;
        chk($sformatf("v%0d post-abort tx", idx), v.sel ? tx1 : tx0, 1'b1);
        return;
      end
      is_tick = (k % v.period) == 0;
      st = (k == v.spur_k) || (v.start_at_end && is_tick && (t + 1 == total));
      drive(st, is_tick, st ? 8'hFF : 8'($urandom), v.sel);
      @(posedge clk); #1;
      if (is_tick) t++;
      bi  = t / 16;
      etx = (t >= total) ? 1'b1 : ((bi < nb) ? bits[bi] : 1'b1);
      chk($sformatf("v%0d tx k=%0d", idx, k), v.sel ? tx1 : tx0, etx);
      chk($sformatf("v%0d busy k=%0d", idx, k), v.sel ? busy1 : busy0, 1'(t < total));
      chk($sformatf("v%0d done k=%0d", idx, k), v.sel ? done1 : done0,
          1'(is_tick && (t == total)));
    end
    drive(1'b0, 1'b0, 8'($urandom), v.sel);
    if (v.tail) begin
      for (int j = 0; j < 16; j++) begin
        drive(1'b0, 1'(j % 2), 8'($urandom), v.sel);
        @(posedge clk); #1;
        chk($sformatf("v%0d idle tx", idx), v.sel ? tx1 : tx0, 1'b1);
        chk($sformatf("v%0d idle busy", idx), v.sel ? busy1 : busy0, 1'b0);
        chk($sformatf("v%0d idle done", idx), v.sel ? done1 : done0, 1'b0);
      end
      drive(1'b0, 1'b0, 8'h00, v.sel);
    end
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{8'hA5, 8'b10100101, 1'b0, 4, 1'b0, -1,  1'b0, -1,  1'b1};
    tbl[1] = '{8'h3C, 8'b00111100, 1'b0, 4, 1'b0, 100, 1'b1, -1,  1'b1};
    tbl[2] = '{8'h01, 8'b10000000, 1'b1, 4, 1'b0, -1,  1'b0, -1,  1'b0};
    tbl[3] = '{8'h80, 8'b00000001, 1'b1, 4, 1'b0, -1,  1'b0, -1,  1'b1};
    tbl[4] = '{8'h55, 8'b10101010, 1'b0, 4, 1'b0, -1,  1'b0, 280, 1'b0};
    tbl[5] = '{8'h55, 8'b10101010, 1'b0, 4, 1'b0, -1,  1'b0, -1,  1'b1};
    tbl[6] = '{8'h00, 8'b00000000, 1'b0, 4, 1'b1, -1,  1'b0, -1,  1'b1};
    tbl[7] = '{8'h07, 8'b11100000, 1'b1, 2, 1'b0, -1,  1'b0, -1,  1'b1};
    tbl[8] = '{8'h03, 8'b11000000, 1'b0, 3, 1'b0, 37,  1'b0, -1,  1'b1};
    tbl[9] = '{8'hFF, 8'b11111111, 1'b0, 1, 1'b0, -1,  1'b1, -1,  1'b1};

    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tx_start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx",        tx0,   1'b1);
    chk("reset busy",      busy0, 1'b0);
    chk("reset done",      done0, 1'b0);
    chk("reset tx sb32",   tx1,   1'b1);
    chk("reset busy sb32", busy1, 1'b0);
    chk("reset done sb32", done1, 1'b0);
    reset = 1'b1;
    // Ticks with no request must leave the line idle.
    for (int j = 0; j < 8; j++) begin
      drive(1'b0, 1'b1, 8'($urandom), 1'b0);
      @(posedge clk); #1;
      chk("pre idle tx", tx0, 1'b1);
    end

    for (int i = 0; i < 10; i++) run_frame(i, tbl[i]);

    for (int i = 0; i < 12; i++) begin
      rv.data = 8'($urandom);
      for (int b = 0; b < 8; b++) rv.seq[7-b] = (rv.data >> b) & 8'h01;
      rv.par          = 1'($countones(rv.data) % 2);
      rv.period       = int'($urandom_range(1, 5));
      rv.sel          = 1'($urandom_range(0, 1));
      rv.spur_k       = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 150)) : -1;
      rv.start_at_end = 1'($urandom_range(0, 1));
      rv.abort_k      = -1;
      rv.tail         = 1'($urandom_range(0, 1));
      run_frame(100 + i, rv);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
